mdr_unit: RTL and testbench
===========================

// Module: mdr_unit
// PURPOSE
//  Parametrised memory data register with integrated source mux. Loads from memory
//  (Data_to_CPU) through a wait-state read sequencer, or from the CPU bus with
//  per-byte enables. Sits between the memory interface and the datapath bus.
//  The CPU control FSM stalls on busy and proceeds on MDR_valid.
// PARAMETERS
//  DATA_W    16  register/bus/memory data width; must be a multiple of 8
//  MEM_WAIT  2   memory read latency in cycles (0..15); 0 = same-edge capture
//  LANES     DATA_W/8  byte lanes (derived localparam, not overridable)
// PORTS
//  Clk            in   1        system clock; all state updates on rising edge
//  Reset          in   1        synchronous, active-high reset
//  LD_MDR         in   1        load request strobe, sampled each rising edge
//  MIO_EN         in   1        source select: 1 = memory read, 0 = bus load
//  BE             in   LANES    byte enables for bus loads; ignored for memory reads
//  Data_to_CPU    in   DATA_W   read data from memory
//  Data_from_Bus  in   DATA_W   data from the internal CPU bus
//  MDR            out  DATA_W   register contents
//  MDR_valid      out  1        one-cycle pulse: memory-read data now in MDR
//  busy           out  1        read in progress; new requests are dropped
//  mem_rd         out  1        memory read strobe, held for the whole wait period
// BEHAVIOUR
//  Reset (sync, active-high): MDR=0, MDR_valid=0, busy=0, mem_rd=0, state=IDLE,
//   cnt=0. Reset during RD_WAIT aborts the read; no MDR_valid is produced.
//  FSM states: IDLE, RD_WAIT.
//  IDLE, LD_MDR=1, MIO_EN=0 (bus load), edge E:
//   - MDR[8i+:8] <= Data_from_Bus[8i+:8] for each lane with BE[i]=1; other lanes hold.
//   - BE=0 -> MDR unchanged. No MDR_valid. Stay IDLE.
//  IDLE, LD_MDR=1, MIO_EN=1 (memory read), edge E0:
//   - MEM_WAIT=0: MDR <= Data_to_CPU at E0; MDR_valid=1 in the cycle after E0;
//     busy and mem_rd never assert.
//   - MEM_WAIT=N>=1: go to RD_WAIT with cnt=N-1; busy=mem_rd=1 from E0 to E_N.
//     In RD_WAIT: cnt!=0 -> decrement. cnt==0 at edge E_N -> MDR <= Data_to_CPU
//     (full width, BE ignored), return to IDLE, MDR_valid=1 for one cycle.
//  RD_WAIT, any LD_MDR: dropped, with no queueing and no side effects. The control
//   FSM holds requests off while busy=1.
//  Back-to-back: a request in the cycle where MDR_valid=1 (state IDLE) is accepted.
//  MDR_valid, busy and mem_rd are registered outputs with no combinational input paths.
//  cnt width = $clog2(MEM_WAIT+1), minimum 1. The counter never wraps; it only
//   decrements while cnt!=0.
//  Elaboration check: DATA_W%8!=0 or MEM_WAIT>15 -> $error.
// STRUCTURE
//  mdr_pkg: mdr_state_e {IDLE, RD_WAIT}, localparam BYTE_W=8, MAX_MEM_WAIT=15.
//  Sub-module mdr_byte_merge (combinational): inputs old value, new value and BE;
//   output is the lane-merged word. Used for bus loads.
//  mdr_unit contains the FSM, the wait counter and the MDR register.
// TESTING
//  1 Reset asserted mid-operation -> all outputs 0 on the next edge, state IDLE.
//  2 DATA_W=16, MEM_WAIT=2, Data_to_CPU=16'hBEEF, one-cycle LD_MDR with MIO_EN=1
//    -> busy/mem_rd high for 2 cycles; MDR=16'hBEEF with MDR_valid pulsed once.
//  3 Bus load: MDR=16'h1234, Data_from_Bus=16'hABCD, BE=2'b01 -> MDR=16'h12CD;
//    BE=2'b10 -> 16'hAB34; BE=2'b00 -> unchanged; MDR_valid stays 0.
//  4 LD_MDR with MIO_EN=0 issued while busy -> MDR unchanged by the bus data;
//    the pending read still completes with the memory value.
//  5 MEM_WAIT=0, Data_to_CPU=16'h00FF -> MDR=16'h00FF one edge after the request;
//    busy never asserts; MDR_valid pulses once.
//  6 Reset asserted at cycle 1 of a MEM_WAIT=3 read -> no MDR_valid, MDR=0;
//    a new read issued immediately after reset completes normally.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types and constants for the memory data register unit.
package mdr_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mdr_state_e;

    localparam int BYTE_W       = 8;
    localparam int MAX_MEM_WAIT = 15;

endpackage

// File: rtl/mdr_byte_merge.sv
// Lane merge for bus loads: each lane takes the new byte when its enable is set,
// otherwise keeps the old byte. Purely combinational.
module mdr_byte_merge
    import mdr_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES*BYTE_W-1:0] i_old,
    input  logic [LANES*BYTE_W-1:0] i_new,
    input  logic [LANES-1:0]        i_be,
    output logic [LANES*BYTE_W-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < LANES; i++) begin
            if (i_be[i]) begin
                o_merged[i*BYTE_W +: BYTE_W] = i_new[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/mdr_unit.sv
// Memory data register with source mux: wait-state memory read sequencer or
// byte-enabled bus load. Requests arriving during a read are dropped.
module mdr_unit
    import mdr_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MEM_WAIT = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       LD_MDR,
    input  logic                       MIO_EN,
    input  logic [DATA_W/BYTE_W-1:0]   BE,
    input  logic [DATA_W-1:0]          Data_to_CPU,
    input  logic [DATA_W-1:0]          Data_from_Bus,
    output logic [DATA_W-1:0]          MDR,
    output logic                       MDR_valid,
    output logic                       busy,
    output logic                       mem_rd
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int CNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    if ((DATA_W % BYTE_W) != 0 || MEM_WAIT > MAX_MEM_WAIT || MEM_WAIT < 0) begin : g_param_check
        $error("mdr_unit: DATA_W must be a multiple of 8 and MEM_WAIT in 0..15");
    end

    mdr_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_mdr, w_mdr_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic [DATA_W-1:0] w_merged;

    mdr_byte_merge #(.LANES(LANES)) u_merge (
        .i_old    (r_mdr),
        .i_new    (Data_from_Bus),
        .i_be     (BE),
        .o_merged (w_merged)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mdr   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mdr   <= w_mdr_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // busy/valid are computed one edge ahead so the outputs come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mdr_nxt   = r_mdr;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (LD_MDR) begin
                    if (!MIO_EN) begin
                        w_mdr_nxt = w_merged;
                    end else if (MEM_WAIT == 0) begin
                        w_mdr_nxt   = Data_to_CPU;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_busy_nxt = 1'b1;
                end else begin
                    w_mdr_nxt   = Data_to_CPU;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign MDR       = r_mdr;
    assign MDR_valid = r_valid;
    assign busy      = r_busy;
    assign mem_rd    = r_busy;

endmodule

// File: tb/tb_mdr_unit.sv
// Directed self-checking bench for mdr_unit at MEM_WAIT = 2, 0 and 3.
module tb_mdr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mio;
    logic [1:0]  be;
    logic [15:0] d_mem;
    logic [15:0] d_bus;
    logic        ld2, ld0, ld3;

    logic [15:0] mdr2, mdr0, mdr3;
    logic        vld2, vld0, vld3;
    logic        bsy2, bsy0, bsy3;
    logic        rd2, rd0, rd3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdr_unit #(.DATA_W(16), .MEM_WAIT(2)) u_dut2 (
        .Clk(clk), .Reset(rst), .LD_MDR(ld2), .MIO_EN(mio), .BE(be),
        .Data_to_CPU(d_mem), .Data_from_Bus(d_bus),
        .MDR(mdr2), .MDR_valid(vld2), .busy(bsy2), .mem_rd(rd2)
    );

    mdr_unit #(.DATA_W(16), .MEM_WAIT(0)) u_dut0 (
        .Clk(clk), .Reset(rst), .LD_MDR(ld0), .MIO_EN(mio), .BE(be),
        .Data_to_CPU(d_mem), .Data_from_Bus(d_bus),
        .MDR(mdr0), .MDR_valid(vld0), .busy(bsy0), .mem_rd(rd0)
    );

    mdr_unit #(.DATA_W(16), .MEM_WAIT(3)) u_dut3 (
        .Clk(clk), .Reset(rst), .LD_MDR(ld3), .MIO_EN(mio), .BE(be),
        .Data_to_CPU(d_mem), .Data_from_Bus(d_bus),
        .MDR(mdr3), .MDR_valid(vld3), .busy(bsy3), .mem_rd(rd3)
    );

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // bus-load dut3 and start a read on dut2 so reset has something to clear
        mio = 1'b0; be = 2'b11; d_bus = 16'h9999; ld3 = 1'b1;
        tick();
        ld3 = 1'b0; mio = 1'b1; d_mem = 16'h4242; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        n_cmp++;
        if (bsy2 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b want 1", bsy2); end
        n_cmp++;
        if (mdr3 !== 16'h9999) begin n_bad++; $display("FAIL rst_pre_mdr3: got %h want 9999", mdr3); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({mdr2, vld2, bsy2, rd2} !== 19'd0) begin
            n_bad++; $display("FAIL rst_dut2: got mdr=%h v=%b b=%b r=%b want all 0", mdr2, vld2, bsy2, rd2);
        end
        n_cmp++;
        if ({mdr3, vld3, bsy3, rd3} !== 19'd0) begin
            n_bad++; $display("FAIL rst_dut3: got mdr=%h v=%b b=%b r=%b want all 0", mdr3, vld3, bsy3, rd3);
        end
        n_cmp++;
        if ({mdr0, vld0, bsy0, rd0} !== 19'd0) begin
            n_bad++; $display("FAIL rst_dut0: got mdr=%h v=%b b=%b r=%b want all 0", mdr0, vld0, bsy0, rd0);
        end
        // the aborted read must not deliver later
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (vld2 !== 1'b0 || mdr2 !== 16'h0) begin
                n_bad++; $display("FAIL rst_abort_%0d: got v=%b mdr=%h want 0/0000", i, vld2, mdr2);
            end
        end
    endtask

    task automatic test_mem_read();
        int pulses;
        pulses = 0;
        mio = 1'b1; d_mem = 16'hBEEF; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bsy2 !== 1'b1 || rd2 !== 1'b1 || vld2 !== 1'b0) begin
                n_bad++; $display("FAIL rd_wait_%0d: got b=%b r=%b v=%b want 1/1/0", i, bsy2, rd2, vld2);
            end
            tick();
        end
        n_cmp++;
        if (mdr2 !== 16'hBEEF || vld2 !== 1'b1 || bsy2 !== 1'b0 || rd2 !== 1'b0) begin
            n_bad++; $display("FAIL rd_done: got mdr=%h v=%b b=%b r=%b want BEEF/1/0/0", mdr2, vld2, bsy2, rd2);
        end
        for (int i = 0; i < 3; i++) begin
            if (vld2 === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 1 || mdr2 !== 16'hBEEF) begin
            n_bad++; $display("FAIL rd_pulse: got pulses=%0d mdr=%h want 1/BEEF", pulses, mdr2);
        end
    endtask

    task automatic test_bus_load();
        logic [1:0]  be_v  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic [15:0] pre_v [4] = '{16'h0000, 16'h1234, 16'h1234, 16'h1234};
        logic [15:0] bus_v [4] = '{16'h1234, 16'hABCD, 16'hABCD, 16'hABCD};
        logic [15:0] exp_v [4] = '{16'h1234, 16'h12CD, 16'hAB34, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            // reload the 1234 baseline before each partial write
            if (i > 0) begin
                mio = 1'b0; be = 2'b11; d_bus = pre_v[i]; ld2 = 1'b1;
                tick();
            end
            mio = 1'b0; be = be_v[i]; d_bus = bus_v[i]; ld2 = 1'b1;
            tick();
            ld2 = 1'b0;
            n_cmp++;
            if (mdr2 !== exp_v[i] || vld2 !== 1'b0 || bsy2 !== 1'b0) begin
                n_bad++; $display("FAIL bus_be%b: got mdr=%h v=%b b=%b want %h/0/0", be_v[i], mdr2, vld2, bsy2, exp_v[i]);
            end
        end
        mio = 1'b0; be = 2'b10; d_bus = 16'hAB00; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        n_cmp++;
        if (mdr2 !== 16'hAB34) begin n_bad++; $display("FAIL bus_setup: got %h want AB34", mdr2); end
    endtask

    task automatic test_busy_drop();
        mio = 1'b1; d_mem = 16'h5A5A; ld2 = 1'b1;
        tick();
        mio = 1'b0; be = 2'b11; d_bus = 16'hFFFF; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        n_cmp++;
        if (mdr2 !== 16'hAB34 || bsy2 !== 1'b1) begin
            n_bad++; $display("FAIL drop_hold: got mdr=%h b=%b want AB34/1", mdr2, bsy2);
        end
        tick();
        n_cmp++;
        if (mdr2 !== 16'h5A5A || vld2 !== 1'b1) begin
            n_bad++; $display("FAIL drop_done: got mdr=%h v=%b want 5A5A/1", mdr2, vld2);
        end
        tick();
        n_cmp++;
        if (bsy2 !== 1'b0 || vld2 !== 1'b0) begin
            n_bad++; $display("FAIL drop_after: got b=%b v=%b want 0/0 (no queued request)", bsy2, vld2);
        end
    endtask

    task automatic test_back_to_back();
        mio = 1'b1; d_mem = 16'h1111; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (vld2 !== 1'b1 || mdr2 !== 16'h1111) begin
            n_bad++; $display("FAIL b2b_first: got v=%b mdr=%h want 1/1111", vld2, mdr2);
        end
        d_mem = 16'hC3C3; ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        n_cmp++;
        if (bsy2 !== 1'b1 || vld2 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept: got b=%b v=%b want 1/0", bsy2, vld2);
        end
        tick();
        tick();
        n_cmp++;
        if (vld2 !== 1'b1 || mdr2 !== 16'hC3C3) begin
            n_bad++; $display("FAIL b2b_second: got v=%b mdr=%h want 1/C3C3", vld2, mdr2);
        end
    endtask

    task automatic test_wait0();
        int pulses;
        int busy_seen;
        pulses = 0; busy_seen = 0;
        mio = 1'b1; d_mem = 16'h00FF; ld0 = 1'b1;
        tick();
        ld0 = 1'b0;
        n_cmp++;
        if (mdr0 !== 16'h00FF || vld0 !== 1'b1) begin
            n_bad++; $display("FAIL w0_capture: got mdr=%h v=%b want 00FF/1", mdr0, vld0);
        end
        for (int i = 0; i < 4; i++) begin
            if (vld0 === 1'b1) pulses++;
            if (bsy0 !== 1'b0 || rd0 !== 1'b0) busy_seen++;
            tick();
        end
        n_cmp++;
        if (pulses != 1 || busy_seen != 0) begin
            n_bad++; $display("FAIL w0_pulse: got pulses=%0d busy_cycles=%0d want 1/0", pulses, busy_seen);
        end
    endtask

    task automatic test_reset_wait3();
        int pulses;
        pulses = 0;
        mio = 1'b1; d_mem = 16'h7777; ld3 = 1'b1;
        tick();
        ld3 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (vld3 === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || mdr3 !== 16'h0000 || bsy3 !== 1'b0) begin
            n_bad++; $display("FAIL w3_abort: got pulses=%0d mdr=%h b=%b want 0/0000/0", pulses, mdr3, bsy3);
        end
        d_mem = 16'h2468; ld3 = 1'b1;
        tick();
        ld3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bsy3 !== 1'b1 || rd3 !== 1'b1 || vld3 !== 1'b0) begin
                n_bad++; $display("FAIL w3_wait_%0d: got b=%b r=%b v=%b want 1/1/0", i, bsy3, rd3, vld3);
            end
            tick();
        end
        n_cmp++;
        if (mdr3 !== 16'h2468 || vld3 !== 1'b1 || bsy3 !== 1'b0) begin
            n_bad++; $display("FAIL w3_done: got mdr=%h v=%b b=%b want 2468/1/0", mdr3, vld3, bsy3);
        end
    endtask

    initial begin
        rst = 1'b1; mio = 1'b0; be = 2'b00; d_mem = '0; d_bus = '0;
        ld2 = 1'b0; ld0 = 1'b0; ld3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_mem_read();
        test_bus_load();
        test_busy_drop();
        test_back_to_back();
        test_wait0();
        test_reset_wait3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
